plru_victim_select: RTL and testbench

- Per-set tree pseudo-LRU replacement engine for an N-way set-associative cache, generalised from the fixed 4-way, 3-bit LRU victim encoder.
- Holds PLRU tree state for every set, updates it on hit/fill "touch" events, and returns a registered victim way on request.
- Selects an invalid way first; otherwise it selects the PLRU way.
- Sits beside the cache controller and tag/valid arrays; also supports a multi-cycle flush of all replacement state.

---
 rtl/plru_victim_select_pkg.sv | 16 +
 rtl/plru_tree_logic.sv | 62 ++++++
 rtl/plru_victim_select.sv | 97 +++++++++
 tb/tb_plru_victim_select.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/plru_victim_select_pkg.sv
// Shared types and default sizing for the tree pseudo-LRU victim selector.
package plru_victim_select_pkg;

  localparam int unsigned DEFAULT_NUM_WAYS = 4;
  localparam int unsigned DEFAULT_NUM_SETS = 8;

  // One set's PLRU tree at the default associativity (NUM_WAYS-1 heap-ordered bits).
  typedef logic [DEFAULT_NUM_WAYS-2:0] plru_tree_t;

  // Flush sequencer states.
  typedef enum logic {
    ST_IDLE,
    ST_FLUSHING
  } flush_state_e;

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational PLRU tree helpers: victim walk with invalid-first priority,
// and next-tree computation for a touched way.
module plru_tree_logic #(
  parameter  int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] i_req_tree,
  input  logic [NUM_WAYS-1:0] i_req_valid_vec,
  output logic [WAY_W-1:0]    o_victim,
  input  logic [NUM_WAYS-2:0] i_touch_tree,
  input  logic [WAY_W-1:0]    i_touch_way,
  output logic [NUM_WAYS-2:0] o_touch_tree_next
);

  logic [2*NUM_WAYS-2:0] w_reach;
  logic [WAY_W-1:0]      w_plru_way;
  logic [WAY_W-1:0]      w_inv_way;
  logic                  w_has_inv;

  // Walk from the root: mark each reached node's LRU child; exactly one leaf ends up marked.
  always_comb begin
    w_reach    = '0;
    w_reach[0] = 1'b1;
    for (int unsigned j = 0; j < NUM_WAYS - 1; j++) begin
      if (w_reach[j]) begin
        if (i_req_tree[j]) w_reach[2*j+2] = 1'b1;
        else               w_reach[2*j+1] = 1'b1;
      end
    end
    w_plru_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (w_reach[NUM_WAYS-1+w]) w_plru_way = WAY_W'(w);
    end
  end

  // Lowest-index invalid way, if any.
  always_comb begin
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!i_req_valid_vec[w] && !w_has_inv) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign o_victim = w_has_inv ? w_inv_way : w_plru_way;

  // Level l holds nodes (2^l - 1) + k; the path node is k == touch_way >> (WAY_W - l),
  // and it is pointed away from the side the touched way lies on.
  always_comb begin
    o_touch_tree_next = i_touch_tree;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      for (int unsigned k = 0; k < (32'd1 << l); k++) begin
        if ((32'(i_touch_way) >> (WAY_W - l)) == k)
          o_touch_tree_next[(32'd1 << l) - 1 + k] = ~i_touch_way[WAY_W-1-l];
      end
    end
  end

endmodule

// File: rtl/plru_victim_select.sv
// Per-set tree pseudo-LRU replacement engine: registered victim lookup,
// touch updates and a one-set-per-cycle flush sequencer.
module plru_victim_select
  import plru_victim_select_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = DEFAULT_NUM_WAYS,
  parameter  int unsigned NUM_SETS = DEFAULT_NUM_SETS,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [SET_W-1:0]    req_set,
  input  logic [NUM_WAYS-1:0] req_valid_vec,
  output logic                resp_valid,
  output logic [WAY_W-1:0]    resp_way,
  input  logic                touch_valid,
  input  logic [SET_W-1:0]    touch_set,
  input  logic [WAY_W-1:0]    touch_way,
  input  logic                flush,
  output logic                ready
);

  logic [NUM_WAYS-2:0] r_tree [NUM_SETS];
  flush_state_e        r_state;
  logic [SET_W-1:0]    r_flush_cnt;
  logic                r_ready;
  logic                r_resp_valid;
  logic [WAY_W-1:0]    r_resp_way;

  logic [NUM_WAYS-2:0] w_req_tree;
  logic [NUM_WAYS-2:0] w_touch_tree;
  logic [NUM_WAYS-2:0] w_touch_tree_next;
  logic [WAY_W-1:0]    w_victim;

  assign w_req_tree   = r_tree[req_set];
  assign w_touch_tree = r_tree[touch_set];

  plru_tree_logic #(
    .NUM_WAYS(NUM_WAYS)
  ) u_tree_logic (
    .i_req_tree        (w_req_tree),
    .i_req_valid_vec   (req_valid_vec),
    .o_victim          (w_victim),
    .i_touch_tree      (w_touch_tree),
    .i_touch_way       (touch_way),
    .o_touch_tree_next (w_touch_tree_next)
  );

  assign resp_valid = r_resp_valid;
  assign resp_way   = r_resp_way;
  assign ready      = r_ready;

  // Tree storage, response register and flush sequencer; a same-cycle request
  // sees the pre-touch tree because the victim is read from the registered state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tree       <= '{default: '0};
      r_state      <= ST_IDLE;
      r_flush_cnt  <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_way   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_way   <= w_victim;
          end
          if (flush) begin
            r_state     <= ST_FLUSHING;
            r_ready     <= 1'b0;
            r_flush_cnt <= '0;
          end else if (touch_valid) begin
            r_tree[touch_set] <= w_touch_tree_next;
          end
        end
        ST_FLUSHING: begin
          r_tree[r_flush_cnt] <= '0;
          r_flush_cnt         <= r_flush_cnt + 1'b1;
          if (r_flush_cnt == SET_W'(NUM_SETS - 1)) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plru_victim_select.sv
// Scoreboard bench for plru_victim_select: a 4-way/8-set and an 8-way/16-set instance.
module tb_plru_victim_select;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_req_valid;
  logic [2:0] a_req_set;
  logic [3:0] a_vec;
  logic       a_resp_valid;
  logic [1:0] a_resp_way;
  logic       a_touch_valid;
  logic [2:0] a_touch_set;
  logic [1:0] a_touch_way;
  logic       a_flush;
  logic       a_ready;

  logic       b_req_valid;
  logic [3:0] b_req_set;
  logic [7:0] b_vec;
  logic       b_resp_valid;
  logic [2:0] b_resp_way;
  logic       b_touch_valid;
  logic [3:0] b_touch_set;
  logic [2:0] b_touch_way;
  logic       b_flush;
  logic       b_ready;

  int checks = 0;
  int errors = 0;
  int a_q[$];
  int b_q[$];

  always #5 clk = ~clk;

  plru_victim_select #(
    .NUM_WAYS(4),
    .NUM_SETS(8)
  ) u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (a_req_valid),
    .req_set       (a_req_set),
    .req_valid_vec (a_vec),
    .resp_valid    (a_resp_valid),
    .resp_way      (a_resp_way),
    .touch_valid   (a_touch_valid),
    .touch_set     (a_touch_set),
    .touch_way     (a_touch_way),
    .flush         (a_flush),
    .ready         (a_ready)
  );

  plru_victim_select #(
    .NUM_WAYS(8),
    .NUM_SETS(16)
  ) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (b_req_valid),
    .req_set       (b_req_set),
    .req_valid_vec (b_vec),
    .resp_valid    (b_resp_valid),
    .resp_way      (b_resp_way),
    .touch_valid   (b_touch_valid),
    .touch_set     (b_touch_set),
    .touch_way     (b_touch_way),
    .flush         (b_flush),
    .ready         (b_ready)
  );

  // Monitor: every presented response pops the oldest expected way.
  always @(negedge clk) begin
    if (a_resp_valid) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_resp_unexpected: got resp_valid=1 way=%0d, required no response", a_resp_way);
      end else begin
        int e;
        e = a_q.pop_front();
        if (int'(a_resp_way) != e) begin
          errors++;
          $display("FAIL a_resp_way: got %0d, required %0d", a_resp_way, e);
        end
      end
    end
    if (b_resp_valid) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_resp_unexpected: got resp_valid=1 way=%0d, required no response", b_resp_way);
      end else begin
        int e;
        e = b_q.pop_front();
        if (int'(b_resp_way) != e) begin
          errors++;
          $display("FAIL b_resp_way: got %0d, required %0d", b_resp_way, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    a_req_valid   = 1'b0;
    a_touch_valid = 1'b0;
    a_flush       = 1'b0;
    b_req_valid   = 1'b0;
    b_touch_valid = 1'b0;
    b_flush       = 1'b0;
  endtask

  task automatic a_req(input int s, input int v, input int e);
    a_req_valid = 1'b1;
    a_req_set   = 3'(s);
    a_vec       = 4'(v);
    a_q.push_back(e);
  endtask

  task automatic a_touch(input int s, input int w);
    a_touch_valid = 1'b1;
    a_touch_set   = 3'(s);
    a_touch_way   = 2'(w);
  endtask

  task automatic b_req(input int s, input int v, input int e);
    b_req_valid = 1'b1;
    b_req_set   = 4'(s);
    b_vec       = 8'(v);
    b_q.push_back(e);
  endtask

  task automatic b_touch(input int s, input int w);
    b_touch_valid = 1'b1;
    b_touch_set   = 4'(s);
    b_touch_way   = 3'(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_set = '0; a_vec = '0;
    a_touch_valid = 1'b0; a_touch_set = '0; a_touch_way = '0; a_flush = 1'b0;
    b_req_valid = 1'b0; b_req_set = '0; b_vec = '0;
    b_touch_valid = 1'b0; b_touch_set = '0; b_touch_way = '0; b_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("a_ready_reset", a_ready, 1);
    chk("a_resp_valid_reset", a_resp_valid, 0);
    chk("a_resp_way_reset", a_resp_way, 0);
    chk("b_ready_reset", b_ready, 1);

    // Fresh trees walk to way 0.
    a_req(3, 'hF, 0); b_req(9, 'hFF, 0); tick();
    // A: set 3 tree -> 3'b011. B: way 5 touched, walk still lands in left half.
    a_touch(3, 0); b_touch(9, 5); tick();
    a_req(3, 'hF, 2); b_req(9, 'hFF, 0); tick();
    // A: tree -> 3'b110. B: way 0 touched on top of way 5.
    a_touch(3, 2); b_touch(9, 0); tick();
    a_req(3, 'hF, 1); b_req(9, 'hFF, 6); tick();
    // Invalid-first priority.
    b_touch(9, 6); a_req(5, 'b1011, 2); tick();
    a_req(5, 'b0000, 0); b_req(9, 'hFF, 2); tick();
    a_req(5, 'b0111, 3); b_req(9, 'h7F, 7); tick();
    // Same-cycle touch and request: victim from pre-touch tree.
    a_touch(1, 0); a_req(1, 'hF, 0); tick();
    a_req(1, 'hF, 2); tick();

    // Flush: a concurrent touch is dropped; inputs ignored while not ready.
    a_touch(2, 1); tick();
    a_touch(6, 3); tick();
    a_flush = 1'b1; a_touch(4, 0); tick();
    chk("a_ready_after_flush", a_ready, 0);
    n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      a_req_valid = 1'b1; a_req_set = 3'd3; a_vec = 4'hF;
      a_touch(0, 0);
      a_flush = 1'b1;
      tick();
      n++;
    end
    chk("a_flush_busy_cycles", n, 8);
    for (int s = 0; s < 8; s++) begin
      a_req(s, 'hF, 0); tick();
    end

    // Reset in the third flush cycle aborts the flush and clears everything.
    a_touch(7, 0); b_touch(3, 0); tick();
    a_flush = 1'b1; tick();
    tick(); tick();
    chk("a_ready_mid_flush", a_ready, 0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("a_ready_after_abort", a_ready, 1);
    chk("a_resp_valid_after_abort", a_resp_valid, 0);
    for (int s = 0; s < 8; s++) begin
      a_req(s, 'hF, 0); tick();
    end
    b_req(3, 'hFF, 0); tick();
    b_req(15, 'hFF, 0); tick();

    repeat (3) tick();
    chk("a_pending_responses", a_q.size(), 0);
    chk("b_pending_responses", b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
